// File: rtl/uart_transmitter_cfg.sv
// uart_transmitter_cfg: configurable UART transmitter.
// Sends start bit, DATA_WIDTH data bits LSB first, an optional even/odd
// parity bit and one or two stop bits. The divider, parity mode and stop
// count are captured when a frame is accepted, so the configuration inputs
// may change at any time without disturbing a frame in flight.
module uart_transmitter_cfg #(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  clk_main,
   input  logic                  rst_n_main,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic [DIV_WIDTH-1:0]  baud_div,
   input  logic [1:0]            parity_mode,
   input  logic                  stop2,
   input  logic                  tx_break,
   output logic                  transmitter_tx,
   output logic                  tx_busy,
   output logic                  frame_done
);

   localparam int IDX_W = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // Current state and frame context
   state_t                state_q, state_n;
   logic [DIV_WIDTH-1:0]  cnt_q, cnt_n;        // position inside the current bit
   logic [IDX_W-1:0]      idx_q, idx_n;        // data bit being sent
   logic                  stop_idx_q, stop_idx_n;
   logic [DATA_WIDTH-1:0] shift_q, shift_n;    // remaining data, LSB on the line
   logic                  par_q, par_n;        // parity bit for this frame
   logic                  par_en_q, par_en_n;
   logic                  stop2_q, stop2_n;
   logic [DIV_WIDTH-1:0]  div_q, div_n;

   // Registered outputs and their next values
   logic tx_q, tx_n;
   logic ready_q, ready_n;
   logic done_q, done_n;

   logic accept;
   logic tc;
   logic last_stop;

   assign accept    = tx_valid && ready_q;
   assign tc        = (cnt_q == div_q);
   assign last_stop = (stop_idx_q == stop2_q);

   // State register: all sequential state, cleared asynchronously
   // NOTE: non-blocking assignments here so every register samples the
   // pre-edge values computed by the combinational processes below.
   always_ff @(posedge clk_main or negedge rst_n_main) begin
      if (!rst_n_main) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         par_en_q   <= 1'b0;
         stop2_q    <= 1'b0;
         div_q      <= '0;
         tx_q       <= 1'b1;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         idx_q      <= idx_n;
         stop_idx_q <= stop_idx_n;
         shift_q    <= shift_n;
         par_q      <= par_n;
         par_en_q   <= par_en_n;
         stop2_q    <= stop2_n;
         div_q      <= div_n;
         tx_q       <= tx_n;
         ready_q    <= ready_n;
         done_q     <= done_n;
      end
   end

   // Next-state logic: bit timing, sequencing and frame capture
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_n    = state_q;
      cnt_n      = cnt_q;
      idx_n      = idx_q;
      stop_idx_n = stop_idx_q;
      shift_n    = shift_q;
      par_n      = par_q;
      par_en_n   = par_en_q;
      stop2_n    = stop2_q;
      div_n      = div_q;

      case (state_q)
         IDLE: ;
         START: begin
            if (tc) begin
               state_n = DATA;
               cnt_n   = '0;
               idx_n   = '0;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (tc) begin
               cnt_n   = '0;
               shift_n = shift_q >> 1;
               if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                  state_n    = par_en_q ? PARITY : STOP;
                  stop_idx_n = 1'b0;
               end else begin
                  idx_n = idx_q + 1'b1;
               end
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         PARITY: begin
            if (tc) begin
               state_n    = STOP;
               cnt_n      = '0;
               stop_idx_n = 1'b0;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (tc) begin
               cnt_n = '0;
               if (last_stop) begin
                  state_n = IDLE;
               end else begin
                  stop_idx_n = 1'b1;
               end
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      // Acceptance is only possible when ready is high: in IDLE or in the
      // final cycle of the last stop bit, so it overrides the moves above.
      if (accept) begin
         state_n    = START;
         cnt_n      = '0;
         idx_n      = '0;
         stop_idx_n = 1'b0;
         shift_n    = tx_data;
         par_en_n   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
         par_n      = (parity_mode == 2'b10) ? ~(^tx_data) : (^tx_data);
         stop2_n    = stop2;
         div_n      = baud_div;
      end
   end

   // Output logic: registered line level, ready and completion pulse
   always_comb begin
      tx_n    = 1'b1;
      ready_n = 1'b0;
      case (state_n)
         IDLE: begin
            tx_n    = ~tx_break;
            ready_n = ~tx_break;
         end
         START:  tx_n = 1'b0;
         DATA:   tx_n = shift_n[0];
         PARITY: tx_n = par_n;
         STOP: begin
            tx_n    = 1'b1;
            // Ready during the final cycle of the last stop bit allows the
            // next frame to start without an idle gap.
            ready_n = (cnt_n == div_n) && (stop_idx_n == stop2_n);
         end
         default: tx_n = 1'b1;
      endcase
      done_n = (state_q == STOP) && tc && last_stop;
   end

   assign transmitter_tx = tx_q;
   assign tx_ready       = ready_q;
   assign frame_done     = done_q;
   assign tx_busy        = (state_q != IDLE);

endmodule
